// File: rtl/mem_usage_fifo.sv
// Byte FIFO that tracks live and peak occupancy for the hex-display path.
// It also raises sticky flags when a push or pop has to be rejected.
module mem_usage_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 100,
   parameter int unsigned AW    = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             full,
   output logic             empty,
   output logic [7:0]       mem_used,
   output logic [7:0]       peak_used,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [7:0]    DEPTH_CNT = 8'(DEPTH);
   localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]       used_q, used_d;
   logic [7:0]       peak_q, peak_d;
   logic             full_q, empty_q;
   logic             rd_valid_q;
   logic [WIDTH-1:0] rd_data_q;
   logic             overflow_q, underflow_q;
   logic             push_ok, pop_ok;

   // A full FIFO still takes a push when a pop frees a slot on the same edge.
   assign push_ok = wr_en & (~full_q | rd_en);
   assign pop_ok  = rd_en & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      used_d   = used_q;
      if (push_ok) begin
         wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_ok, pop_ok})
         2'b10:   used_d = used_q + 8'd1;
         2'b01:   used_d = used_q - 8'd1;
         default: used_d = used_q;
      endcase
      peak_d = (used_d > peak_q) ? used_d : peak_q;
   end

   // Storage carries no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (!clear && push_ok) begin
         mem[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         used_q      <= '0;
         peak_q      <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (clear) begin
         // rd_data deliberately keeps the last popped word across a flush.
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         used_q      <= '0;
         peak_q      <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         used_q     <= used_d;
         peak_q     <= peak_d;
         full_q     <= (used_d == DEPTH_CNT);
         empty_q    <= (used_d == 8'd0);
         rd_valid_q <= pop_ok;
         if (pop_ok) begin
            rd_data_q <= mem[rd_ptr_q];
         end
         if (wr_en && full_q && !rd_en) begin
            overflow_q <= 1'b1;
         end
         if (rd_en && empty_q) begin
            underflow_q <= 1'b1;
         end
      end
   end

   assign rd_data   = rd_data_q;
   assign rd_valid  = rd_valid_q;
   assign full      = full_q;
   assign empty     = empty_q;
   assign mem_used  = used_q;
   assign peak_used = peak_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_mem_usage_fifo.sv
// Randomised bench for mem_usage_fifo; a queue-based model supplies every expected value.
module tb_mem_usage_fifo;

   localparam int DEPTH = 100;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       clear;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic [7:0] mem_used;
   logic [7:0] peak_used;
   logic       overflow;
   logic       underflow;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] m_q[$];
   int         m_peak;
   logic       m_ovf, m_unf, m_rdv;
   logic [7:0] m_data;

   mem_usage_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AW(7)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .full      (full),
      .empty     (empty),
      .mem_used  (mem_used),
      .peak_used (peak_used),
      .overflow  (overflow),
      .underflow (underflow)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_q.delete();
      m_peak = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_rdv  = 1'b0;
      m_data = 8'h00;
   endtask

   // One clock edge of the FIFO's documented behaviour, at transaction level.
   task automatic model_step();
      bit is_full, is_empty, pop, push;
      if (clear) begin
         m_q.delete();
         m_peak = 0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         m_rdv  = 1'b0;
         return;
      end
      is_full  = (m_q.size() == DEPTH);
      is_empty = (m_q.size() == 0);
      pop      = rd_en && !is_empty;
      push     = wr_en && (!is_full || rd_en);
      if (wr_en && is_full && !rd_en) m_ovf = 1'b1;
      if (rd_en && is_empty) m_unf = 1'b1;
      m_rdv = pop;
      if (pop) m_data = m_q.pop_front();
      if (push) m_q.push_back(wr_data);
      if (m_q.size() > m_peak) m_peak = m_q.size();
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step();
      #1;
   endtask

   task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      clear   = c;
   endtask

   task automatic test_reset();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      model_reset();
      repeat (2) cycle();
      reset_n = 1'b1;
      cycle();
      n_cmp++; if (mem_used !== 8'd0) begin n_err++; $display("FAIL reset_used: got %0d want 0", mem_used); end
      n_cmp++; if (peak_used !== 8'd0) begin n_err++; $display("FAIL reset_peak: got %0d want 0", peak_used); end
      n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags: empty %b full %b want 1 0", empty, full); end
      n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0 || rd_valid !== 1'b0) begin
         n_err++; $display("FAIL reset_sticky: ovf %b unf %b rdv %b want 0 0 0", overflow, underflow, rd_valid);
      end
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
   endtask

   task automatic test_order();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 8'(i), 1'b0, 1'b0);
         cycle();
      end
      for (int i = 1; i <= 10; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0);
         cycle();
         n_cmp++; if (rd_valid !== 1'b1 || rd_data !== m_data || rd_data !== 8'(i)) begin
            n_err++; $display("FAIL order_pop%0d: got v=%b d=%0h want v=1 d=%0h", i, rd_valid, rd_data, i);
         end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cycle();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL order_valid_drop: got %b want 0", rd_valid); end
      n_cmp++; if (mem_used !== 8'd0 || peak_used !== 8'd10 || empty !== 1'b1) begin
         n_err++; $display("FAIL order_end: used %0d peak %0d empty %b want 0 10 1", mem_used, peak_used, empty);
      end
   endtask

   task automatic test_full();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 8'($urandom), 1'b0, 1'b0);
         cycle();
      end
      n_cmp++; if (full !== 1'b1 || mem_used !== 8'd100 || empty !== 1'b0) begin
         n_err++; $display("FAIL full_reach: full %b used %0d want 1 100", full, mem_used);
      end
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      cycle();
      n_cmp++; if (overflow !== 1'b1 || mem_used !== 8'd100 || full !== 1'b1) begin
         n_err++; $display("FAIL full_overflow: ovf %b used %0d want 1 100", overflow, mem_used);
      end
      // 110 simultaneous push/pop cycles walk the read pointer across the 99->0 wrap.
      for (int i = 0; i < 110; i++) begin
         drive(1'b1, 8'($urandom), 1'b1, 1'b0);
         cycle();
         n_cmp++; if (rd_valid !== 1'b1 || rd_data !== m_data || mem_used !== 8'd100 || full !== 1'b1) begin
            n_err++; $display("FAIL full_pushpop%0d: v=%b d=%0h used %0d want v=1 d=%0h used 100",
                              i, rd_valid, rd_data, mem_used, m_data);
         end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_ovf_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_empty();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      n_cmp++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || mem_used !== 8'd0) begin
         n_err++; $display("FAIL empty_pop: unf %b rdv %b used %0d want 1 0 0", underflow, rd_valid, mem_used);
      end
      drive(1'b1, 8'h5A, 1'b1, 1'b0);
      cycle();
      n_cmp++; if (mem_used !== 8'd1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
         n_err++; $display("FAIL empty_pushpop: used %0d rdv %b empty %b want 1 0 0", mem_used, rd_valid, empty);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      n_cmp++; if (rd_data !== 8'h5A || rd_valid !== 1'b1) begin
         n_err++; $display("FAIL empty_drain: d=%0h v=%b want 5a 1", rd_data, rd_valid);
      end
   endtask

   task automatic test_clear();
      logic [7:0] held;
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
      for (int i = 0; i < 37; i++) begin drive(1'b1, 8'($urandom), 1'b0, 1'b0); cycle(); end
      for (int i = 0; i < 12; i++) begin drive(1'b0, 8'h00, 1'b1, 1'b0); cycle(); end
      for (int i = 0; i < 5; i++) begin drive(1'b1, 8'($urandom), 1'b0, 1'b0); cycle(); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      cycle();
      n_cmp++; if (mem_used !== 8'd30 || peak_used !== 8'd37) begin
         n_err++; $display("FAIL clear_mix: used %0d peak %0d want 30 37", mem_used, peak_used);
      end
      held = m_data;
      drive(1'b1, 8'h33, 1'b1, 1'b1);
      cycle();
      n_cmp++; if (mem_used !== 8'd0 || peak_used !== 8'd0 || empty !== 1'b1 || full !== 1'b0 ||
                   overflow !== 1'b0 || underflow !== 1'b0 || rd_valid !== 1'b0) begin
         n_err++; $display("FAIL clear_state: used %0d peak %0d empty %b ovf %b unf %b rdv %b want 0 0 1 0 0 0",
                           mem_used, peak_used, empty, overflow, underflow, rd_valid);
      end
      n_cmp++; if (rd_data !== held) begin n_err++; $display("FAIL clear_rd_hold: got %0h want %0h", rd_data, held); end
   endtask

   task automatic test_sweep();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
      for (int i = 1; i <= DEPTH; i++) begin
         drive(1'b1, 8'($urandom), 1'b0, 1'b0);
         cycle();
         n_cmp++; if (mem_used !== 8'(i) || full !== (i == DEPTH) || empty !== 1'b0 ||
                      peak_used !== 8'(m_peak)) begin
            n_err++; $display("FAIL sweep%0d: used %0d full %b empty %b peak %0d", i, mem_used, full, empty, peak_used);
         end
      end
   endtask

   task automatic test_random();
      bit wr_bias;
      for (int i = 0; i < 3000; i++) begin
         wr_bias = ((i / 250) % 2) == 0;
         drive(($urandom_range(99) < (wr_bias ? 80 : 25)), 8'($urandom),
               ($urandom_range(99) < (wr_bias ? 25 : 80)), ($urandom_range(199) == 0));
         cycle();
         n_cmp++; if (mem_used !== 8'(m_q.size()) || peak_used !== 8'(m_peak) ||
                      full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0) ||
                      overflow !== m_ovf || underflow !== m_unf || rd_valid !== m_rdv ||
                      rd_data !== m_data) begin
            n_err++; $display("FAIL random%0d: used %0d/%0d peak %0d/%0d ovf %b/%b unf %b/%b v %b/%b d %0h/%0h",
                              i, mem_used, m_q.size(), peak_used, m_peak, overflow, m_ovf,
                              underflow, m_unf, rd_valid, m_rdv, rd_data, m_data);
         end
      end
   endtask

   task automatic test_async_reset();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      cycle();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      for (int i = 0; i < 20; i++) begin drive(1'b1, 8'($urandom_range(255, 1)), 1'b0, 1'b0); cycle(); end
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      cycle();
      drive(1'b1, 8'h11, 1'b1, 1'b0);
      reset_n = 1'b0;
      #1;
      n_cmp++; if (mem_used !== 8'd0 || peak_used !== 8'd0 || empty !== 1'b1 || full !== 1'b0 ||
                   rd_valid !== 1'b0 || rd_data !== 8'h00 || overflow !== 1'b0 || underflow !== 1'b0) begin
         n_err++; $display("FAIL async_reset: used %0d peak %0d empty %b rdv %b d %0h unf %b want 0 0 1 0 0 0",
                           mem_used, peak_used, empty, rd_valid, rd_data, underflow);
      end
      model_reset();
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      cycle();
      reset_n = 1'b1;
      drive(1'b1, 8'h77, 1'b0, 1'b0);
      cycle();
      n_cmp++; if (mem_used !== 8'd1 || peak_used !== 8'd1) begin
         n_err++; $display("FAIL async_release: used %0d peak %0d want 1 1", mem_used, peak_used);
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full();
      test_empty();
      test_clear();
      test_sweep();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
